dts_align_ctrl: RTL and testbench
=================================

# dts_align_ctrl

Closed-loop skew controller for a bank of `dts_offsetter` instances. It watches the `dout_sync` output of every offsetter and measures each lane's sync arrival against lane 0. It then issues single-step `advance`/`delay` pulses to each offsetter until all syncs coincide, and reports alignment status. It sits in the offsetters' `clk_out` domain, between the offsetter bank and the downstream DTS deformatter/packetizer.

## Interface
Parameters:
- `N_LANES`, 4: number of offsetter lanes; lane 0 is the timing reference and is never adjusted.
- `WINDOW`, 64: measurement window in cycles; maximum correctable skew is ±(`WINDOW`-1).
- `PULSE_CYCLES`, 4: high time of each `advance`/`delay` pulse. Keeps the pulse wide enough to be edge-detected in the offsetter's `clk_in` domain.
- `SETTLE_CYCLES`, 128: wait after a correction round before re-measuring. Must be ≥ offsetter FIFO propagation.
- `MAX_ITER`, 255: correction rounds allowed before declaring failure.

Ports:
- `clk` in 1: controller clock, same as offsetter `clk_out`.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level; low forces IDLE.
- `sync` in N_LANES: `dout_sync` from each offsetter.
- `almost_full` in N_LANES: offsetter FIFO status, pre-synchronised to `clk`.
- `almost_empty` in N_LANES: offsetter FIFO status, pre-synchronised to `clk`.
- `advance` out N_LANES: per-lane advance pulse to the offsetter.
- `delay` out N_LANES: per-lane delay pulse to the offsetter.
- `aligned` out 1: all lanes at zero offset.
- `busy` out 1: state ≠ IDLE/LOCKED/FAIL.
- `fail` out 1: sticky until `enable` low; iteration limit reached or FIFO guard tripped.
- `missing` out N_LANES: lane sync not seen in last window.
- `offset` out N_LANES*8: last measured signed offset per lane, lane i at [8i+7:8i], two's complement, saturated to ±127.

## Operation
- States: IDLE, ARM, MEASURE, ADJUST, PULSE, SETTLE, LOCKED, FAIL.
- IDLE: outputs quiet, iteration counter cleared. `enable`=1 → ARM.
- ARM: wait for first `sync` on any lane. That cycle starts the epoch: timer=0, and lanes syncing this cycle get timestamp 0. → MEASURE.
- MEASURE: the timer counts 0..2*`WINDOW`-1. The first sync on each lane latches its timestamp; later syncs in the same epoch are ignored. At timer end:
  - offset_i = t_i − t_0.
  - Lanes with no sync set `missing[i]`.
  - If lane 0 is missing, or any lane is missing → FAIL.
  - If all offsets are 0 → LOCKED.
  - Otherwise → ADJUST.
- ADJUST: for each lane i≥1:
  - offset>0 (lane late) → request advance.
  - offset<0 (lane early) → request delay.
  - Exactly one step per lane per round.
  - FIFO guard: an advance request with `almost_empty[i]`, or a delay request with `almost_full[i]`, → FAIL with no pulses issued.
  - Increment iteration counter; counter = `MAX_ITER` → FAIL. Otherwise → PULSE.
- PULSE: drive the requested `advance`/`delay` bits high for `PULSE_CYCLES`, all lanes simultaneously. A lane never has both bits high. → SETTLE.
- SETTLE: wait `SETTLE_CYCLES`, ignoring `sync`. → ARM.
- LOCKED: `aligned`=1. Stays until `enable` low.
- FAIL: `fail`=1, no pulses. Stays until `enable` low.
- `enable` deasserted in any state → IDLE next cycle. This also drops any pulse in flight; the offsetter edge detector then sees a short pulse, which is acceptable.

## Timing
- Reset (async, `rst_n`=0): state IDLE; `advance`, `delay`, `aligned`, `busy`, `fail`, `missing`, `offset` all 0; counters 0.
- Outputs are registered; state decisions take effect on the clock edge after the qualifying input.
- A round lasts: (ARM wait) + 2*`WINDOW` + 1 (ADJUST) + `PULSE_CYCLES` + `SETTLE_CYCLES` cycles.
- `offset` and `missing` update in the cycle MEASURE exits and hold until the next MEASURE exit.
- Reset asserted mid-PULSE: `advance`/`delay` drop asynchronously.

## Configuration
- `DTS_ALIGN_CTRL_MONITOR_EN` defined: LOCKED keeps cycling ARM/MEASURE in the background with `aligned`=1 held.
  - Any nonzero offset or missing lane clears `aligned`, clears the iteration counter, and re-enters ADJUST (or FAIL if a lane is missing).
  - `offset` keeps updating.
- Undefined: LOCKED is terminal as described above; no measurement logic is active after lock.

## Structure
- Package `dts_align_pkg`: state enum, `OFFSET_W`=8, saturation helper function, timer width derived as clog2(2*`WINDOW`).
- Sub-module `dts_lane_skew_meas` (one per lane): first-sync timestamp capture, seen flag, clear on epoch start.
- The top level holds the FSM, iteration/pulse/settle counters, offset arithmetic and the FIFO guard.

## Test plan
- Lanes 1..3 sync at +3, −2, 0 cycles vs lane 0 → exactly 3 advance pulses on lane 1, 2 delay pulses on lane 2, none on lane 3; then `aligned`=1 and offset=0,0,0.
- All lanes coincident at enable → no pulses, LOCKED after one MEASURE.
- Lane 2 sync never arrives → `missing`=4'b0100, `fail`=1, no pulses.
- Lane 1 at +5 with `almost_empty[1]`=1 → FAIL in ADJUST, zero pulses on all lanes.
- Lane 1 model ignores pulses (constant +1) with `MAX_ITER`=4 → 3 pulses, then `fail`=1.
- MONITOR_EN: after lock, inject a +1 skew on lane 3 → `aligned` drops, 1 advance on lane 3, relock. `rst_n` low during PULSE → all outputs 0 immediately.

Source files
------------

// File: rtl/dts_align_pkg.sv
// Shared types and helpers for the DTS lane alignment controller.
package dts_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_ADJUST,
    ST_PULSE,
    ST_SETTLE,
    ST_LOCKED,
    ST_FAIL
  } state_e;

  localparam int OFFSET_W   = 8;
  localparam int OFFSET_MAX = 2 ** (OFFSET_W - 1) - 1;

  // The epoch timer spans two windows so both early and late lanes fit.
  function automatic int timer_w(input int window);
    return $clog2(2 * window);
  endfunction

  // Symmetric saturation keeps -128 unused so magnitudes are mirror images.
  function automatic logic signed [OFFSET_W-1:0] sat_offset(input logic signed [31:0] val);
    if (val > OFFSET_MAX) return OFFSET_W'(OFFSET_MAX);
    else if (val < -OFFSET_MAX) return OFFSET_W'(-OFFSET_MAX);
    return OFFSET_W'(val);
  endfunction

endpackage

// File: rtl/dts_lane_skew_meas.sv
// Per-lane first-sync timestamp capture for one measurement epoch.
module dts_lane_skew_meas
  import dts_align_pkg::*;
#(
  parameter int TW = timer_w(64)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          capture_i,
  input  logic          sync_i,
  input  logic [TW-1:0] timer_i,
  output logic          seen_o,
  output logic [TW-1:0] ts_o
);

  logic          seen_q, seen_d;
  logic [TW-1:0] ts_q, ts_d;

  always_comb begin
    seen_d = seen_q;
    ts_d   = ts_q;
    if (clear_i) begin
      seen_d = sync_i;
      ts_d   = '0;
    end else if (capture_i && sync_i && !seen_q) begin
      seen_d = 1'b1;
      ts_d   = timer_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= 1'b0;
      ts_q   <= '0;
    end else begin
      seen_q <= seen_d;
      ts_q   <= ts_d;
    end
  end

  // Bypass lets a sync on the last timer cycle still count for this epoch.
  assign seen_o = seen_q | (capture_i & sync_i);
  assign ts_o   = seen_q ? ts_q : timer_i;

endmodule

// File: rtl/dts_align_ctrl.sv
// Closed-loop skew controller for a bank of DTS offsetters (lane 0 is the reference).
// Optional background monitoring after lock: define DTS_ALIGN_CTRL_MONITOR_EN.
module dts_align_ctrl
  import dts_align_pkg::*;
#(
  parameter int N_LANES       = 4,
  parameter int WINDOW        = 64,
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 128,
  parameter int MAX_ITER      = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [N_LANES-1:0]            sync,
  input  logic [N_LANES-1:0]            almost_full,
  input  logic [N_LANES-1:0]            almost_empty,
  output logic [N_LANES-1:0]            advance,
  output logic [N_LANES-1:0]            delay,
  output logic                          aligned,
  output logic                          busy,
  output logic                          fail,
  output logic [N_LANES-1:0]            missing,
  output logic [N_LANES*OFFSET_W-1:0]   offset
);

  localparam int TW    = timer_w(WINDOW);
  localparam int CNT_W = $clog2((SETTLE_CYCLES > PULSE_CYCLES ? SETTLE_CYCLES : PULSE_CYCLES) + 1);
  localparam int IT_W  = $clog2(MAX_ITER + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(2 * WINDOW - 1);

`ifdef DTS_ALIGN_CTRL_MONITOR_EN
  localparam bit MON_EN = 1'b1;
`else
  localparam bit MON_EN = 1'b0;
`endif

  state_e                      state_q, state_d;
  logic [TW-1:0]               timer_q, timer_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IT_W-1:0]             iter_q, iter_d, iter_inc;
  logic                        lock_meas_q, lock_meas_d;
  logic [N_LANES-1:0]          adv_q, adv_d, dly_q, dly_d;
  logic [N_LANES-1:0]          missing_q, missing_d;
  logic                        aligned_q, aligned_d, busy_q, busy_d, fail_q, fail_d;
  logic [N_LANES*OFFSET_W-1:0] offset_q, offset_d;

  logic                        arming, measuring, epoch_start, meas_end;
  logic [N_LANES-1:0]          seen;
  logic [TW-1:0]               ts [N_LANES];
  logic signed [OFFSET_W-1:0]  meas_off [N_LANES];
  logic                        all_zero, any_missing, guard_trip;
  logic [N_LANES-1:0]          req_adv, req_dly;

  // With monitoring enabled, LOCKED alternates arming and measuring via lock_meas_q.
  assign arming      = (state_q == ST_ARM) || (MON_EN && (state_q == ST_LOCKED) && !lock_meas_q);
  assign measuring   = (state_q == ST_MEASURE) || (MON_EN && (state_q == ST_LOCKED) && lock_meas_q);
  assign epoch_start = arming && (|sync);
  assign meas_end    = measuring && (timer_q == TIMER_LAST);
  assign iter_inc    = iter_q + IT_W'(1);

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    dts_lane_skew_meas #(.TW(TW)) u_meas (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (epoch_start),
      .capture_i (measuring),
      .sync_i    (sync[g]),
      .timer_i   (timer_q),
      .seen_o    (seen[g]),
      .ts_o      (ts[g])
    );
  end

  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < N_LANES; i++) begin
      meas_off[i] = (seen[i] && seen[0]) ? sat_offset(int'(ts[i]) - int'(ts[0])) : '0;
      if (meas_off[i] != '0) all_zero = 1'b0;
    end
    any_missing = ~&seen;
  end

  // Correction requests come from the offsets latched at the end of MEASURE.
  always_comb begin
    req_adv = '0;
    req_dly = '0;
    for (int i = 1; i < N_LANES; i++) begin
      req_dly[i] = offset_q[i*OFFSET_W + OFFSET_W - 1];
      req_adv[i] = !req_dly[i] && (offset_q[i*OFFSET_W +: OFFSET_W] != '0);
    end
    guard_trip = |((req_adv & almost_empty) | (req_dly & almost_full));
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cnt_d       = cnt_q;
    iter_d      = iter_q;
    lock_meas_d = lock_meas_q;
    adv_d       = '0;
    dly_d       = '0;
    missing_d   = missing_q;
    offset_d    = offset_q;

    // The sync cycle that opens the epoch is timer 0, so counting resumes at 1.
    if (epoch_start) timer_d = TW'(1);
    else if (measuring) timer_d = timer_q + TW'(1);

    if (meas_end) begin
      missing_d = ~seen;
      for (int i = 0; i < N_LANES; i++) offset_d[i*OFFSET_W +: OFFSET_W] = meas_off[i];
    end

    case (state_q)
      ST_IDLE: begin
        iter_d      = '0;
        lock_meas_d = 1'b0;
        if (enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (epoch_start) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (meas_end) begin
          if (any_missing) state_d = ST_FAIL;
          else if (all_zero) state_d = ST_LOCKED;
          else state_d = ST_ADJUST;
        end
      end
      ST_ADJUST: begin
        if (guard_trip) begin
          state_d = ST_FAIL;
        end else begin
          iter_d = iter_inc;
          if (iter_inc == IT_W'(MAX_ITER)) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_PULSE;
            adv_d   = req_adv;
            dly_d   = req_dly;
            cnt_d   = '0;
          end
        end
      end
      ST_PULSE: begin
        adv_d = adv_q;
        dly_d = dly_q;
        if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
          adv_d   = '0;
          dly_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (MON_EN) begin
          if (!lock_meas_q) begin
            if (epoch_start) lock_meas_d = 1'b1;
          end else if (meas_end) begin
            lock_meas_d = 1'b0;
            if (any_missing) begin
              state_d = ST_FAIL;
            end else if (!all_zero) begin
              iter_d  = '0;
              state_d = ST_ADJUST;
            end
          end
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable) begin
      state_d     = ST_IDLE;
      adv_d       = '0;
      dly_d       = '0;
      lock_meas_d = 1'b0;
    end

    aligned_d = (state_d == ST_LOCKED);
    fail_d    = (state_d == ST_FAIL);
    busy_d    = !((state_d == ST_IDLE) || (state_d == ST_LOCKED) || (state_d == ST_FAIL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      cnt_q       <= '0;
      iter_q      <= '0;
      lock_meas_q <= 1'b0;
      adv_q       <= '0;
      dly_q       <= '0;
      missing_q   <= '0;
      offset_q    <= '0;
      aligned_q   <= 1'b0;
      busy_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      iter_q      <= iter_d;
      lock_meas_q <= lock_meas_d;
      adv_q       <= adv_d;
      dly_q       <= dly_d;
      missing_q   <= missing_d;
      offset_q    <= offset_d;
      aligned_q   <= aligned_d;
      busy_q      <= busy_d;
      fail_q      <= fail_d;
    end
  end

  assign advance = adv_q;
  assign delay   = dly_q;
  assign aligned = aligned_q;
  assign busy    = busy_q;
  assign fail    = fail_q;
  assign missing = missing_q;
  assign offset  = offset_q;

endmodule

// File: tb/tb_dts_align_ctrl.sv
// Scoreboard bench for dts_align_ctrl with a behavioural offsetter bank and outcome model.
module tb_dts_align_ctrl;

  localparam int NL    = 4;
  localparam int WIN   = 8;
  localparam int PC    = 2;
  localparam int SC    = 6;
  localparam int MAXI  = 4;
  localparam int PER   = 40;
  localparam int BASE  = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [NL-1:0]   sync, af, ae;
  logic [NL-1:0]   advance, delay, missing;
  logic            aligned, busy, fail;
  logic [NL*8-1:0] offset;

  dts_align_ctrl #(
    .N_LANES(NL), .WINDOW(WIN), .PULSE_CYCLES(PC), .SETTLE_CYCLES(SC), .MAX_ITER(MAXI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sync(sync),
    .almost_full(af), .almost_empty(ae), .advance(advance), .delay(delay),
    .aligned(aligned), .busy(busy), .fail(fail), .missing(missing), .offset(offset)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NL-1:0] adv;
    logic [NL-1:0] dly;
  } pulse_t;

  typedef struct {
    bit              aligned;
    bit              fail;
    logic [NL-1:0]   missing;
    logic [NL*8-1:0] offs;
    logic [NL-1:0]   offmask;
  } final_t;

  pulse_t q_pulse[$];
  final_t q_final[$];
  int     checks = 0;
  int     errors = 0;
  bit     abort  = 1'b0;
  int     cyc    = 0;
  int     skew[NL];
  bit     present[NL];
  bit     stuck[NL];
  int     al_fall = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offsetter bank: each lane emits a sync at BASE+skew in every PER-cycle frame;
  // an advance pulse moves the lane one cycle earlier, a delay pulse one cycle later.
  initial begin
    logic [NL-1:0] a_prev, d_prev;
    a_prev = '0;
    d_prev = '0;
    sync   = '0;
    for (int i = 0; i < NL; i++) begin
      skew[i] = 0; present[i] = 1'b1; stuck[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NL; i++) begin
        if (advance[i] && !a_prev[i] && !stuck[i]) skew[i]--;
        if (delay[i] && !d_prev[i] && !stuck[i]) skew[i]++;
      end
      a_prev = advance;
      d_prev = delay;
      for (int i = 0; i < NL; i++) sync[i] = present[i] && ((cyc % PER) == BASE + skew[i]);
    end
  end

  // Reference model: plays out correction rounds on plain integer skews.
  task automatic model(input int s_in[NL], input logic [NL-1:0] pres, input logic [NL-1:0] stk,
                       input logic [NL-1:0] ae_v, input logic [NL-1:0] af_v);
    int s[NL];
    int iter;
    pulse_t p;
    final_t f;
    logic [NL-1:0] a, d;
    s = s_in;
    iter = 0;
    for (int r = 0; r < 16; r++) begin
      f.aligned = 1'b0;
      f.fail    = 1'b1;
      f.missing = ~pres;
      f.offmask = pres[0] ? pres : '0;
      f.offs    = '0;
      for (int i = 0; i < NL; i++) f.offs[8*i +: 8] = 8'(s[i]);
      if (pres != '1) begin q_final.push_back(f); return; end
      a = '0;
      d = '0;
      for (int i = 1; i < NL; i++) begin a[i] = s[i] > 0; d[i] = s[i] < 0; end
      if (a == '0 && d == '0) begin
        f.aligned = 1'b1; f.fail = 1'b0;
        q_final.push_back(f);
        return;
      end
      if (((a & ae_v) | (d & af_v)) != '0) begin q_final.push_back(f); return; end
      iter++;
      if (iter == MAXI) begin q_final.push_back(f); return; end
      p.adv = a;
      p.dly = d;
      q_pulse.push_back(p);
      for (int i = 1; i < NL; i++) if (!stk[i]) s[i] = s[i] - int'(a[i]) + int'(d[i]);
    end
  endtask

  // Monitor: pops expectations whenever a pulse starts or a terminal status rises.
  initial begin
    logic [NL-1:0] pa, pd;
    logic al_p, fl_p;
    int wcnt;
    pulse_t p;
    final_t f;
    logic [NL*8-1:0] om;
    pa = '0; pd = '0; al_p = 1'b0; fl_p = 1'b0; wcnt = 0;
    forever begin
      @(negedge clk);
      if (!abort && rst_n === 1'b1) begin
        if ((advance | delay) != '0 && (pa | pd) == '0) begin
          if (q_pulse.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pulse: advance=%b delay=%b, required no pulse", advance, delay);
          end else begin
            p = q_pulse.pop_front();
            chk("pulse_advance", 64'(advance), 64'(p.adv));
            chk("pulse_delay", 64'(delay), 64'(p.dly));
          end
          chk("pulse_exclusive", 64'(advance & delay), 64'd0);
          chk("busy_during_pulse", 64'(busy), 64'd1);
          wcnt = 0;
        end
        if ((advance | delay) != '0) wcnt++;
        else if ((pa | pd) != '0 && enable) chk("pulse_width", 64'(wcnt), 64'(PC));
        if ((aligned && !al_p) || (fail && !fl_p)) begin
          if (q_final.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_status: aligned=%b fail=%b, required no change", aligned, fail);
          end else begin
            f = q_final.pop_front();
            om = '0;
            for (int i = 0; i < NL; i++) om[8*i +: 8] = {8{f.offmask[i]}};
            chk("final_aligned", 64'(aligned), 64'(f.aligned));
            chk("final_fail", 64'(fail), 64'(f.fail));
            chk("final_missing", 64'(missing), 64'(f.missing));
            chk("final_offset", 64'(offset & om), 64'(f.offs & om));
            chk("final_busy", 64'(busy), 64'd0);
          end
        end
        if (!aligned && al_p) al_fall++;
      end
      pa = advance; pd = delay; al_p = aligned; fl_p = fail;
    end
  end

  task automatic wait_phase(input int ph);
    for (int k = 0; k < 2 * PER && (cyc % PER) != ph; k++) @(negedge clk);
  endtask

  task automatic wait_final(input string name);
    for (int k = 0; k < 2000 && q_final.size() != 0; k++) @(negedge clk);
    if (q_final.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: %0d status events outstanding, required 0", name, q_final.size());
      q_final.delete();
    end
  endtask

  task automatic run_scn(input string name, input int s1, input int s2, input int s3,
                         input logic [NL-1:0] pres_m, input logic [NL-1:0] stuck_m,
                         input logic [NL-1:0] ae_v, input logic [NL-1:0] af_v, input bit keep);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    skew[0] = 0; skew[1] = s1; skew[2] = s2; skew[3] = s3;
    for (int i = 0; i < NL; i++) begin present[i] = pres_m[i]; stuck[i] = stuck_m[i]; end
    ae = ae_v;
    af = af_v;
    model('{0, s1, s2, s3}, pres_m, stuck_m, ae_v, af_v);
    wait_phase(20);
    enable = 1'b1;
    wait_final(name);
    chk("pulses_consumed", 64'(q_pulse.size()), 64'd0);
    q_pulse.delete();
    if (!keep) enable = 1'b0;
  endtask

  initial begin
    int al_before;
    rst_n = 1'b0; enable = 1'b0; ae = '0; af = '0;
    repeat (3) @(negedge clk);
    chk("reset_advance", 64'(advance), 64'd0);
    chk("reset_delay", 64'(delay), 64'd0);
    chk("reset_flags", 64'({aligned, busy, fail}), 64'd0);
    chk("reset_missing", 64'(missing), 64'd0);
    chk("reset_offset", 64'(offset), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_scn("skew_3_m2_0", 3, -2, 0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
    run_scn("coincident", 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
    run_scn("lane2_missing", 0, 0, 0, 4'b1011, 4'h0, 4'h0, 4'h0, 1'b0);
    run_scn("guard_empty", 5, 0, 0, 4'hF, 4'h0, 4'b0010, 4'h0, 1'b0);
    run_scn("guard_full", 0, -1, 2, 4'hF, 4'h0, 4'h0, 4'b0100, 1'b0);
    run_scn("stuck_lane1", 1, 0, 0, 4'hF, 4'b0010, 4'h0, 4'h0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int s1, s2, s3;
      logic [NL-1:0] ae_r, af_r;
      s1 = int'($urandom_range(6)) - 3;
      s2 = int'($urandom_range(6)) - 3;
      s3 = int'($urandom_range(6)) - 3;
      ae_r = 4'($urandom) & 4'($urandom);
      af_r = 4'($urandom) & 4'($urandom);
      run_scn("random", s1, s2, s3, 4'hF, 4'h0, ae_r, af_r, 1'b0);
    end

    // Skew introduced after lock on lane 3.
    run_scn("pre_lock", 2, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1);
    al_before = al_fall;
    wait_phase(30);
`ifdef DTS_ALIGN_CTRL_MONITOR_EN
    begin
      pulse_t p;
      final_t f;
      p.adv = 4'b1000; p.dly = 4'b0000;
      q_pulse.push_back(p);
      f.aligned = 1'b1; f.fail = 1'b0; f.missing = '0; f.offs = '0; f.offmask = 4'hF;
      q_final.push_back(f);
    end
    skew[3] = 1;
    wait_final("relock");
    chk("relock_pulses_consumed", 64'(q_pulse.size()), 64'd0);
    chk("aligned_dropped_once", 64'(al_fall - al_before), 64'd1);
    q_pulse.delete();
`else
    skew[3] = 1;
    repeat (3 * PER) @(negedge clk);
    chk("locked_holds_aligned", 64'(aligned), 64'd1);
    chk("locked_not_busy", 64'(busy), 64'd0);
    chk("locked_offset_frozen", 64'(offset), 64'd0);
    chk("locked_no_drop", 64'(al_fall - al_before), 64'd0);
`endif
    enable = 1'b0;

    // Reset asserted while a pulse is high.
    repeat (3) @(negedge clk);
    skew[0] = 0; skew[1] = 3; skew[2] = 0; skew[3] = 0;
    for (int i = 0; i < NL; i++) begin present[i] = 1'b1; stuck[i] = 1'b0; end
    ae = '0; af = '0;
    model('{0, 3, 0, 0}, 4'hF, 4'h0, 4'h0, 4'h0);
    wait_phase(20);
    enable = 1'b1;
    for (int k = 0; k < 500 && advance == '0; k++) @(negedge clk);
    chk("pulse_before_reset", 64'(advance), 64'b0010);
    abort = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_advance", 64'(advance), 64'd0);
    chk("async_reset_delay", 64'(delay), 64'd0);
    chk("async_reset_flags", 64'({aligned, busy, fail}), 64'd0);
    chk("async_reset_offset", 64'(offset), 64'd0);
    q_pulse.delete();
    q_final.delete();
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;

    run_scn("after_reset", 0, 1, -1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
